ring_head: RTL
==============

Name: ring_head

Overview:
- Ring origin stage. Drives slot 0 of the core ring, feeding core 1.
- Consumes the slot emerging from the last core, which is the same slot the memory controller snoops.
- Owns the resend queue that the memory controller fills with deferred Address and GrantExclusive slots.
- Arbitrates between draining that queue and recirculating ring traffic. Regenerates the single ring Token, with a watchdog for token loss.

Parameters:
- LOGDEPTH, 5: log2 of resend queue depth (32 entries).
- TIMEOUT, 4096: cycles in WAIT without a returning Token before the token is declared lost. Must be ≥ 2.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- RingIn  in  32  slot payload from last core
- SlotTypeIn  in  4  slot type from last core (codebase slot-type defines)
- SourceIn  in  4  slot source from last core
- rqWr  in  1  resend queue write strobe, from memory controller
- rqDin  in  40  resend entry {dest[39:36], type[35:32], payload[31:0]}
- RingOut  out  32  registered slot payload to core 1
- SlotTypeOut  out  4  registered slot type to core 1
- SourceOut  out  4  registered slot source to core 1
- rqFull  out  1  resend queue full
- rqCount  out  LOGDEPTH+1  resend queue occupancy
- tokenLost  out  1  one-cycle pulse when the watchdog fires
- overflow  out  1  sticky: rqWr seen while full

Behaviour:
- Reset (reset=0, async):
  - state=DUMP; RingOut=0, SlotTypeOut=Null, SourceOut=0.
  - Queue emptied, rqCount=0, rqFull=0.
  - tokenLost=0, overflow=0, watchdog=0.
- Resend queue:
  - Synchronous FIFO, depth 2^LOGDEPTH, with a registered head.
  - An entry written in cycle N is first poppable in cycle N+1.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - rqWr while full and no pop in the same cycle: entry dropped, overflow set until reset.
  - rqWr while full with a pop in the same cycle: entry accepted.
  - rqFull = (rqCount == 2^LOGDEPTH).
- DUMP state:
  - Queue not empty: pop the head and drive RingOut=payload, SlotTypeOut=type, SourceOut=dest. One entry per cycle, back-to-back.
  - Queue empty: drive Token (RingOut=0, SourceOut=0), go to WAIT, clear watchdog.
  - Incoming ring slots are discarded in DUMP. The ring is quiescent while the head holds the token.
  - Entries pushed during DUMP are drained in the same DUMP pass if they arrive before the empty check.
- WAIT state:
  - Incoming Token: drive Null, go to DUMP.
  - Incoming Address with RingIn[31]=1 (retry slot that has completed a lap): drive Null. The slot is consumed here.
  - Otherwise: forward the input unchanged (payload, type, source). Latency is 1 cycle.
  - Watchdog increments each WAIT cycle. When it reaches TIMEOUT-1 with no Token arriving that cycle:
    - tokenLost=1 for one cycle.
    - Output Null this cycle, then go to DUMP.
  - Token arrival on the same cycle as the timeout: the Token wins and tokenLost is not pulsed.
- Watchdog width: ceil(log2(TIMEOUT)) bits; saturation is not needed because the counter is cleared on entry to WAIT.
- Reset mid-DUMP or mid-WAIT: queue contents are lost and the output returns to Null immediately (asynchronously).
  - After reset deasserts, the first rising edge emits Token, because the queue is empty.
- No combinational path from inputs to outputs. Every output is registered.

Test Plan:
- Reset release, queue empty → cycle 1 after deassert: SlotTypeOut=Token, RingOut=0, SourceOut=0; the next cycle in WAIT forwards an input {Address, 0x1000_0040, src 3} unchanged one cycle later.
- Push 3 entries {dest 2, GrantExclusive, 0x00000010}, {dest 4, Address, 0x90000020}, {dest 5, Address, 0x90000030} while in WAIT, then return Token → next 3 cycles emit those entries in order; the 4th cycle emits Token; rqCount goes 3→0.
- In WAIT, input Address 0x9000_0040 (bit31=1) → output Null next cycle. Input Address 0x1000_0040 → forwarded. Input WriteData 0xDEADBEEF → forwarded.
- Fill the queue to 32 entries, then push a 33rd → rqFull=1, overflow=1 and sticky, rqCount=32. On the next DUMP, exactly 32 entries drain, followed by Token.
- With TIMEOUT=16, never return Token → tokenLost pulses exactly once, 15 cycles after entering WAIT; the next cycle re-emits Token. Same test with Token arriving on cycle 15 → no pulse.
- Assert reset mid-drain with 10 entries queued → outputs go to Null/0 asynchronously and rqCount=0. After release, Token is emitted with no stale entries.

Source files
------------

// File: rtl/ring_head_if.sv
// ring_head_if: signal bundle between the ring origin stage and its neighbours.
//
// Ring input:   RingIn / SlotTypeIn / SourceIn  - slot emerging from the last core
// Resend write: rqWr / rqDin                     - deferred entries from the memory controller
// Ring output:  RingOut / SlotTypeOut / SourceOut - registered slot to core 1
// Status:       rqFull, rqCount, tokenLost, overflow
// Debug:        dbg_state (0 = DUMP, 1 = WAIT)
//
// Flow control: there is no valid/ready pair. The ring carries one slot every
// cycle (Null marks an empty slot), and rqWr is a one-cycle write strobe that
// is never back-pressured; a write that finds the queue full with no pop in the
// same cycle is dropped and reported through the sticky overflow flag.
interface ring_head_if #(
    parameter int LOGDEPTH = 5
);
    logic [31:0]       RingIn;
    logic [3:0]        SlotTypeIn;
    logic [3:0]        SourceIn;
    logic              rqWr;
    logic [39:0]       rqDin;
    logic [31:0]       RingOut;
    logic [3:0]        SlotTypeOut;
    logic [3:0]        SourceOut;
    logic              rqFull;
    logic [LOGDEPTH:0] rqCount;
    logic              tokenLost;
    logic              overflow;
    logic              dbg_state;

    modport slave (
        input  RingIn, SlotTypeIn, SourceIn, rqWr, rqDin,
        output RingOut, SlotTypeOut, SourceOut, rqFull, rqCount, tokenLost, overflow, dbg_state
    );

    modport master (
        output RingIn, SlotTypeIn, SourceIn, rqWr, rqDin,
        input  RingOut, SlotTypeOut, SourceOut, rqFull, rqCount, tokenLost, overflow, dbg_state
    );
endinterface

// File: rtl/ring_head.sv
// ring_head: ring origin stage. Drives slot 0 of the core ring (into core 1),
// consumes the slot leaving the last core, owns the resend queue filled by the
// memory controller, and regenerates the single ring Token with a loss watchdog.
//
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - ring_head_if.slave (ring in/out, resend queue write, status, debug state)
//
// Slot type encoding: Null=0, Token=1, Address=2, WriteData=3, GrantExclusive=4.
module ring_head #(
    parameter int LOGDEPTH = 5,
    parameter int TIMEOUT  = 4096
) (
    input  logic       clock,
    input  logic       reset,
    ring_head_if.slave bus
);
    localparam int DEPTH = 1 << LOGDEPTH;
    localparam int WDW   = $clog2(TIMEOUT);

    localparam logic [3:0] SLOT_NULL    = 4'd0;
    localparam logic [3:0] SLOT_TOKEN   = 4'd1;
    localparam logic [3:0] SLOT_ADDRESS = 4'd2;

    localparam logic [WDW-1:0]    WD_FIRE    = WDW'(TIMEOUT - 1);
    localparam logic [LOGDEPTH:0] COUNT_FULL = (LOGDEPTH + 1)'(DEPTH);

    typedef enum logic {
        ST_DUMP = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [LOGDEPTH:0]   count_q, count_d;
    logic [LOGDEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOGDEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [WDW-1:0]      wd_q, wd_d;
    logic [31:0]         ring_out_q, ring_out_d;
    logic [3:0]          type_out_q, type_out_d;
    logic [3:0]          src_out_q, src_out_d;
    logic                token_lost_q, token_lost_d;
    logic                overflow_q, overflow_d;

    logic [39:0]         rq_mem [DEPTH];
    logic [39:0]         head;
    logic                empty;
    logic                full;
    logic                pop;
    logic                push;

    assign empty = (count_q == '0);
    assign full  = (count_q == COUNT_FULL);
    assign head  = rq_mem[rd_ptr_q];

    // A write while full is still accepted when the head pops in the same
    // cycle, since that pop frees the slot being written.
    assign push = bus.rqWr && (!full || pop);

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + LOGDEPTH'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + LOGDEPTH'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (LOGDEPTH + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (LOGDEPTH + 1)'(1);
        end
        if (bus.rqWr && !push) begin
            overflow_d = 1'b1;
        end
    end

    // Next-state and output slot. Every path defaults to a Null slot.
    always_comb begin
        state_d      = state_q;
        wd_d         = wd_q;
        ring_out_d   = '0;
        type_out_d   = SLOT_NULL;
        src_out_d    = '0;
        token_lost_d = 1'b0;
        pop          = 1'b0;
        case (state_q)
            ST_DUMP: begin
                // The head holds the token here, so ring input is ignored.
                if (!empty) begin
                    pop        = 1'b1;
                    ring_out_d = head[31:0];
                    type_out_d = head[35:32];
                    src_out_d  = head[39:36];
                end else begin
                    type_out_d = SLOT_TOKEN;
                    state_d    = ST_WAIT;
                    wd_d       = '0;
                end
            end
            ST_WAIT: begin
                wd_d = wd_q + WDW'(1);
                if (bus.SlotTypeIn == SLOT_TOKEN) begin
                    // Token back: absorb it; a fresh one is issued after the dump.
                    state_d = ST_DUMP;
                end else if (wd_d == WD_FIRE) begin
                    token_lost_d = 1'b1;
                    state_d      = ST_DUMP;
                end else if (bus.SlotTypeIn == SLOT_ADDRESS && bus.RingIn[31]) begin
                    // Retry address that has completed a lap is consumed here.
                end else begin
                    ring_out_d = bus.RingIn;
                    type_out_d = bus.SlotTypeIn;
                    src_out_d  = bus.SourceIn;
                end
            end
            default: begin
                state_d = ST_DUMP;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_DUMP;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            wd_q         <= '0;
            ring_out_q   <= '0;
            type_out_q   <= SLOT_NULL;
            src_out_q    <= '0;
            token_lost_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            wd_q         <= wd_d;
            ring_out_q   <= ring_out_d;
            type_out_q   <= type_out_d;
            src_out_q    <= src_out_d;
            token_lost_q <= token_lost_d;
            overflow_q   <= overflow_d;
        end
    end

    // Queue storage needs no reset; the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            rq_mem[wr_ptr_q] <= bus.rqDin;
        end
    end

    assign bus.RingOut     = ring_out_q;
    assign bus.SlotTypeOut = type_out_q;
    assign bus.SourceOut   = src_out_q;
    assign bus.rqFull      = full;
    assign bus.rqCount     = count_q;
    assign bus.tokenLost   = token_lost_q;
    assign bus.overflow    = overflow_q;
    assign bus.dbg_state   = state_q;
endmodule
